// File: rtl/fan_pkg.sv
// Shared fan definitions: FSM state and level encodings, duty width, LED bar map.
// Pure declarations, no latency and no handshaking; the fan timer uses the same level codes.
package fan_pkg;

  localparam int DUTY_W    = 7;
  localparam int PWM_STEPS = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_HOLD = 2'd3
  } fan_state_t;

  typedef enum logic [1:0] {
    LVL_OFF  = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_MID  = 2'd2,
    LVL_HIGH = 2'd3
  } fan_level_t;

  // Nibble n is the bar pattern for level n.
  localparam logic [15:0] LED_BAR_MAP = {4'b0111, 4'b0011, 4'b0001, 4'b0000};

  function automatic logic [3:0] led_bar_of(input fan_level_t lvl);
    return LED_BAR_MAP[{lvl, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// PWM generator: prescaled 0..99 counter, duty latched at each period wrap, registered compare.
// pwm_out lags the counter by 1 clk; no backpressure, duty_cur is sampled only at the wrap.
module fan_pwm_gen
  import fan_pkg::*;
#(
  parameter int PWM_DIV = 100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DUTY_W-1:0] duty_cur,
  output logic              pwm_out
);

  localparam int                PRE_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PWM_DIV - 1);
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_STEPS - 1);

  logic [PRE_W-1:0]  pre_cnt;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] duty_lat;
  logic              adv;

  assign adv = (pre_cnt == PRE_LAST);

  // duty_lat only moves on the period wrap so a period never carries two duties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      duty_lat <= '0;
      pwm_out  <= 1'b0;
    end else begin
      pre_cnt <= adv ? '0 : pre_cnt + 1'b1;
      if (adv) begin
        if (pwm_cnt == CNT_LAST) begin
          pwm_cnt  <= '0;
          duty_lat <= duty_cur;
        end else begin
          pwm_cnt <= pwm_cnt + 1'b1;
        end
      end
      pwm_out <= (pwm_cnt < duty_lat);
    end
  end

endmodule

// File: rtl/fan_pwm_speed_ctrl.sv
// Fan speed control: button/timeout -> level, soft-ramped duty (1 % per ramp tick), PWM and LED bar.
// level/led_bar follow a pulse by 1 clk; pulses are never refused, a new level redirects the ramp.
module fan_pwm_speed_ctrl
  import fan_pkg::*;
#(
  parameter int PWM_DIV  = 100,
  parameter int RAMP_DIV = 1000,
  parameter int DUTY_L   = 30,
  parameter int DUTY_M   = 60,
  parameter int DUTY_H   = 90
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              speed_btn,
  input  logic              timeout,
  output logic              pwm_out,
  output logic [1:0]        level,
  output logic [DUTY_W-1:0] duty_cur,
  output logic [3:0]        led_bar,
  output logic              fan_on,
  output logic              busy
);

  localparam int               RAMP_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

  fan_level_t        level_q;
  fan_state_t        state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target;
  logic [RAMP_W-1:0] ramp_cnt;
  logic              tick;

  // Timeout has priority over a simultaneous button press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= LVL_OFF;
    end else if (timeout) begin
      level_q <= LVL_OFF;
    end else if (speed_btn) begin
      level_q <= fan_level_t'(level_q + 2'd1);
    end
  end

  always_comb begin
    target = '0;
    case (level_q)
      LVL_LOW:  target = DUTY_W'(DUTY_L);
      LVL_MID:  target = DUTY_W'(DUTY_M);
      LVL_HIGH: target = DUTY_W'(DUTY_H);
      default:  target = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ramp_cnt <= '0;
    end else begin
      ramp_cnt <= tick ? '0 : ramp_cnt + 1'b1;
    end
  end

  assign tick = (ramp_cnt == RAMP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
    end
  end

  // Steps are guarded by the live target, so a redirect in the same cycle never overshoots.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    case (state_q)
      ST_IDLE: begin
        if (target != '0) state_d = ST_UP;
      end
      ST_UP: begin
        if (tick && (duty_q < target)) duty_d = duty_q + 1'b1;
        if (target < duty_q)       state_d = ST_DOWN;
        else if (target == duty_q) state_d = (target == '0) ? ST_IDLE : ST_HOLD;
      end
      ST_DOWN: begin
        if (tick && (duty_q > target)) duty_d = duty_q - 1'b1;
        if (target > duty_q)       state_d = ST_UP;
        else if (target == duty_q) state_d = (target == '0) ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        if (target > duty_q)      state_d = ST_UP;
        else if (target < duty_q) state_d = ST_DOWN;
        else if (target == '0)    state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fan_pwm_gen #(
    .PWM_DIV (PWM_DIV)
  ) u_pwm (
    .clk      (clk),
    .reset_n  (reset_n),
    .duty_cur (duty_q),
    .pwm_out  (pwm_out)
  );

  assign level    = level_q;
  assign duty_cur = duty_q;
  assign led_bar  = led_bar_of(level_q);
  assign fan_on   = (duty_q != '0);
  assign busy     = (state_q == ST_UP) || (state_q == ST_DOWN);

endmodule

// File: tb/tb_fan_pwm_speed_ctrl.sv
// Directed bench for fan_pwm_speed_ctrl with PWM_DIV=1, RAMP_DIV=2: level table plus ramp/PWM/reset sequences.
module tb_fan_pwm_speed_ctrl;
  import fan_pkg::*;

  typedef struct {
    logic       btn;
    logic       tout;
    logic [1:0] lvl;
    logic [3:0] led;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       speed_btn;
  logic       timeout;
  logic       pwm_out;
  logic [1:0] level;
  logic [6:0] duty_cur;
  logic [3:0] led_bar;
  logic       fan_on;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  fan_pwm_speed_ctrl #(
    .PWM_DIV  (1),
    .RAMP_DIV (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .speed_btn (speed_btn),
    .timeout   (timeout),
    .pwm_out   (pwm_out),
    .level     (level),
    .duty_cur  (duty_cur),
    .led_bar   (led_bar),
    .fan_on    (fan_on),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Called at a negedge; returns at the negedge after the pulse was sampled.
  task automatic pulse(input logic b, input logic t);
    speed_btn = b;
    timeout   = t;
    @(posedge clk);
    @(negedge clk);
    speed_btn = 1'b0;
    timeout   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    speed_btn = 1'b0;
    timeout   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic int st();
    return int'(dut.state_q);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int   t3_lvl[3];
    int   t3_duty[3];
    int   errs, n, prev, last_step, hc, exp_prev;

    vecs[0]  = '{1'b1, 1'b0, 2'd1, 4'b0001};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 4'b0011};
    vecs[2]  = '{1'b1, 1'b0, 2'd3, 4'b0111};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 4'b0001};
    vecs[5]  = '{1'b1, 1'b1, 2'd0, 4'b0000};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 4'b0000};
    vecs[7]  = '{1'b1, 1'b0, 2'd1, 4'b0001};
    vecs[8]  = '{1'b1, 1'b0, 2'd2, 4'b0011};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 4'b0000};
    vecs[10] = '{1'b1, 1'b0, 2'd1, 4'b0001};
    vecs[11] = '{1'b0, 1'b0, 2'd1, 4'b0001};
    t3_lvl  = '{2, 3, 0};
    t3_duty = '{60, 90, 0};

    // 1: reset and idle
    reset_n   = 1'b0;
    speed_btn = 1'b0;
    timeout   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_level", int'(level), 0);
    check("rst_led_bar", int'(led_bar), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fan_on", int'(fan_on), 0);
    check("rst_duty", int'(duty_cur), 0);
    reset_n = 1'b1;
    errs = 0;
    repeat (500) begin
      @(negedge clk);
      if (pwm_out || level != 2'd0 || led_bar != 4'd0 || busy || fan_on) errs++;
    end
    check("idle_500clk_bad_cycles", errs, 0);

    // 2: one press, ramp to 30, hold, 30 % PWM
    speed_btn = 1'b1;
    check("t2_level_before_edge", int'(level), 0);
    @(posedge clk);
    @(negedge clk);
    speed_btn = 1'b0;
    check("t2_level", int'(level), 1);
    check("t2_led_bar", int'(led_bar), 4'b0001);
    @(negedge clk);
    check("t2_busy", int'(busy), 1);
    check("t2_state_up", st(), 1);
    prev = int'(duty_cur);
    n = 0;
    errs = 0;
    last_step = -10;
    while (duty_cur != 7'd30 && n < 80) begin
      @(negedge clk);
      n++;
      if (int'(duty_cur) != prev) begin
        if (int'(duty_cur) != prev + 1 || n - last_step < 2) errs++;
        last_step = n;
      end
      prev = int'(duty_cur);
    end
    check_range("t2_ramp_clks", n, 58, 61);
    check("t2_ramp_shape_errs", errs, 0);
    @(negedge clk);
    check("t2_state_hold", st(), 3);
    check("t2_busy_after", int'(busy), 0);
    check("t2_fan_on", int'(fan_on), 1);
    repeat (20) @(negedge clk);
    check("t2_no_overshoot", int'(duty_cur), 30);
    repeat (150) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      hc = 0;
      repeat (100) begin
        @(negedge clk);
        hc += int'(pwm_out);
      end
      check($sformatf("t2_pwm_high_per_100_w%0d", w), hc, 30);
    end

    // 3: presses 1000 clk apart -> 2, 3, 0
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0);
      repeat (1000) @(negedge clk);
      check($sformatf("t3_level_%0d", i), int'(level), t3_lvl[i]);
      check($sformatf("t3_duty_%0d", i), int'(duty_cur), t3_duty[i]);
    end
    check("t3_state_idle", st(), 0);
    check("t3_fan_on", int'(fan_on), 0);
    check("t3_busy", int'(busy), 0);

    // 4: timeout while ramping up at duty 50
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check("t4_level3", int'(level), 3);
    n = 0;
    while (duty_cur != 7'd50 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_reached_50", int'(duty_cur), 50);
    pulse(1'b0, 1'b1);
    check("t4_level_after_timeout", int'(level), 0);
    check("t4_no_up_step", int'(duty_cur), 50);
    prev = 50;
    n = 0;
    errs = 0;
    while (duty_cur != 7'd0 && n < 250) begin
      @(negedge clk);
      n++;
      if (int'(duty_cur) > prev || prev - int'(duty_cur) > 1) errs++;
      if (n == 3) check("t4_state_down", st(), 2);
      prev = int'(duty_cur);
    end
    check_range("t4_fall_clks", n, 99, 103);
    check("t4_fall_shape_errs", errs, 0);
    repeat (2) @(negedge clk);
    check("t4_state_idle", st(), 0);
    check("t4_busy", int'(busy), 0);

    // 5: level table, including press+timeout together at level 1
    exp_prev = int'(level);
    for (int i = 0; i < 12; i++) begin
      speed_btn = vecs[i].btn;
      timeout   = vecs[i].tout;
      check($sformatf("vec%0d_level_pre_edge", i), int'(level), exp_prev);
      @(posedge clk);
      @(negedge clk);
      speed_btn = 1'b0;
      timeout   = 1'b0;
      check($sformatf("vec%0d_level", i), int'(level), int'(vecs[i].lvl));
      check($sformatf("vec%0d_led_bar", i), int'(led_bar), int'(vecs[i].led));
      exp_prev = int'(vecs[i].lvl);
    end

    // 6: duty change mid-period is deferred to the wrap; reset mid-ramp
    do_reset();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    repeat (1000) @(negedge clk);
    check("t6_duty_60", int'(duty_cur), 60);
    n = 0;
    while (int'(dut.u_pwm.pwm_cnt) != 40 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_sync_pwm_cnt", int'(dut.u_pwm.pwm_cnt), 40);
    speed_btn = 1'b1;
    hc = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) speed_btn = 1'b0;
      hc += int'(pwm_out);
    end
    check("t6_old_duty_highs_rest_of_period", hc, 20);
    check("t6_level3", int'(level), 3);
    check_range("t6_duty_moved", int'(duty_cur), 87, 90);
    hc = 0;
    repeat (100) begin
      @(negedge clk);
      hc += int'(pwm_out);
    end
    check_range("t6_new_duty_highs", hc, 87, 90);

    pulse(1'b0, 1'b1);
    repeat (10) @(negedge clk);
    n = 0;
    while (!pwm_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_pwm_high_before_rst", int'(pwm_out), 1);
    check("t6_busy_before_rst", int'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_pwm_out", int'(pwm_out), 0);
    check("t6_rst_duty", int'(duty_cur), 0);
    check("t6_rst_level", int'(level), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_led_bar", int'(led_bar), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
